rr_mux3_sequencer: RTL
======================

// Module: rr_mux3_sequencer
// PURPOSE
//  Round-robin sequencer that drives a 3-input, W-bit-lane mux (mux3_<W>) and registers its result.
//  - Upstream: three requesters, each presenting one W-bit lane.
//  - Picks one requester per cycle, drives the mux select, captures the mux output in a
//    one-entry output buffer, and offers it downstream on a valid/ready handshake.
//  - Sits in the ALU multi_mux path, between the operand sources and the result consumer.
// PARAMETERS
//  W      3  lane width; must match the W of the attached mux3_<W>
//  CNT_W  8  width of each per-lane grant counter (saturating)
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        synchronous reset, active high
//  req_valid   in   3        req_valid[i]=1: lane i holds its data at the mux input until acked
//  req_ack     out  3        one-hot, combinational; req_ack[i]=1 in the cycle lane i is captured
//  sel         out  2        to mux s; only values 0..2 are ever driven
//  mux_y       in   W        from mux y; equals lane sel in the same cycle (combinational mux)
//  out_data    out  W        registered result
//  out_valid   out  1        out_data is valid
//  out_ready   in   1        downstream accepts out_data when out_valid & out_ready
//  grant_cnt   out  3*CNT_W  per-lane grant counts, lane i at [i*CNT_W +: CNT_W]
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge):
//   - out_valid=0, out_data=0, sel=0, grant_cnt=0, last=2 (lane 0 has first priority)
//   - state=EMPTY
//   - req_ack=0 while rst=1
//   - Reset mid-operation drops any buffered result; nothing is acked during reset.
//  can_load = (state==EMPTY) | (out_ready).
//  Winner: first i with req_valid[i]=1, scanning last+1, last+2, last (mod 3).
//  Load cycle (can_load & |req_valid):
//   - sel=winner; req_ack[winner]=1
//   - at posedge: out_data<=mux_y, out_valid<=1, last<=winner, grant_cnt[winner]++
//     (grant_cnt saturates at 2^CNT_W-1)
//  No load:
//   - sel holds its previous registered value
//   - req_ack=0, last unchanged
//  FSM:
//   - EMPTY: any req -> load, go to FULL; else stay EMPTY
//   - FULL, out_ready=1, any req: transfer and load in the same cycle; stay FULL (back-to-back)
//   - FULL, out_ready=1, no req: go to EMPTY; out_valid<=0; out_data holds its stale value
//   - FULL, out_ready=0: hold; out_data/out_valid stable; req_ack=0
//  Latency: req -> out_valid is 1 cycle. Throughput: 1 result/cycle while out_ready=1.
//  Only one lane is ever acked per cycle.
//  A lane that is not acked keeps req_valid and data stable (requester rule).
//  Fairness: with all 3 requesting continuously and out_ready=1, grants cycle 0,1,2,0,...
//  Each lane is served within 3 loads of raising req_valid.
//  out_ready while out_valid=0 is ignored.
// TESTING (W=3, lanes at mux: L0=3'b001, L1=3'b010, L2=3'b100)
//  - reset then req_valid=111, out_ready=1 held 6 cycles -> sel=0,1,2,0,1,2;
//    out_data one cycle later =001,010,100,001,010,100
//  - req_valid=010 only, out_ready=1 -> req_ack=010 every cycle; out_valid=1 from 2nd cycle;
//    grant_cnt lane1 +1/cycle
//  - load L2, then out_ready=0 for 4 cycles with req_valid=011 -> out_data=100 held, req_ack=000;
//    out_ready=1 -> next grant lane0 (after last=2)
//  - single req then req_valid=000, out_ready=1 -> out_valid=1 for exactly 1 cycle, then 0; FSM EMPTY
//  - out_valid=1, out_ready=0, assert rst 1 cycle -> next cycle out_valid=0, out_data=0,
//    grant_cnt=0, req_ack=000
//  - CNT_W=2, lane0 only for 5 loads -> grant_cnt lane0 = 3 (saturated), other lanes 0

Source files
------------

// File: rtl/rr_mux3_sequencer_if.sv
// Handshake/bus bundle between the round-robin sequencer, its requesters,
// the attached 3-input mux and the result consumer.
interface rr_mux3_sequencer_if #(
    parameter int W     = 3,
    parameter int CNT_W = 8
);
    logic [2:0]         req_valid;
    logic [2:0]         req_ack;
    logic [1:0]         sel;
    logic [W-1:0]       mux_y;
    logic [W-1:0]       out_data;
    logic               out_valid;
    logic               out_ready;
    logic [3*CNT_W-1:0] grant_cnt;

    modport master (
        input  req_valid, mux_y, out_ready,
        output req_ack, sel, out_data, out_valid, grant_cnt
    );

    modport slave (
        output req_valid, mux_y, out_ready,
        input  req_ack, sel, out_data, out_valid, grant_cnt
    );
endinterface

// File: rtl/rr_mux3_sequencer.sv
// Round-robin sequencer for a 3-input mux: picks one requesting lane per cycle,
// registers the mux result in a one-entry buffer and offers it on valid/ready.
module rr_mux3_sequencer #(
    parameter int W     = 3,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    rr_mux3_sequencer_if.master bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    state_e                  state_q, state_d;
    logic   [W-1:0]          out_data_q;
    logic   [1:0]            last_q;
    logic   [1:0]            sel_q;
    logic   [2:0][CNT_W-1:0] cnt_q;

    logic       any_req;
    logic       can_load;
    logic       load;
    logic [1:0] winner;
    logic [2:0] ack;
    logic [1:0] sel;

    // Priority scan starts just after the last winner, so the last winner goes last.
    always_comb begin
        logic       found;
        logic [1:0] cand;
        found  = 1'b0;
        winner = last_q;
        cand   = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            cand = 2'((int'(last_q) + k) % 3);
            if (!found && bus.req_valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign any_req  = |bus.req_valid;
    assign can_load = (state_q == EMPTY) || bus.out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (any_req) state_d = FULL;
            FULL:  if (bus.out_ready && !any_req) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Outputs: a load happens whenever the buffer can take a new result and someone asks
    always_comb begin
        load = !rst && can_load && any_req;
        ack  = 3'b000;
        sel  = sel_q;
        if (load) begin
            ack[winner] = 1'b1;
            sel         = winner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q <= '0;
            last_q     <= 2'd2;
            sel_q      <= 2'd0;
            cnt_q      <= '0;
        end else if (load) begin
            out_data_q <= bus.mux_y;
            last_q     <= winner;
            sel_q      <= winner;
            if (cnt_q[winner] != {CNT_W{1'b1}})
                cnt_q[winner] <= cnt_q[winner] + 1'b1;
        end
    end

    assign bus.req_ack   = ack;
    assign bus.sel       = sel;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = (state_q == FULL);
    assign bus.grant_cnt = cnt_q;
endmodule
